// File: rtl/phase_sequencer.sv
// One-hot CPU phase generator with stall, phase skipping,
// ready-gated wait phases with a timeout watchdog and a cycle counter.
module phase_sequencer #(
    parameter int                  N_PHASES  = 4,
    parameter logic [N_PHASES-1:0] WAIT_MASK = 4'b1000,
    parameter int                  WAIT_MAX  = 7,
    parameter int                  CNT_W     = 16,
    localparam int                 IDX_W     = $clog2(N_PHASES),
    localparam int                 WC_W      = $clog2(WAIT_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [N_PHASES-1:0] skip_mask,
    input  logic                ready,
    output logic [N_PHASES-1:0] phase,
    output logic [IDX_W-1:0]    phase_idx,
    output logic                phase_first,
    output logic                cycle_done,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [WC_W-1:0] WMAX = WC_W'(WAIT_MAX);

    logic [IDX_W-1:0] idx_q, idx_nxt, succ;
    logic [WC_W-1:0]  wc_q, wc_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             first_q, first_nxt;
    logic             done_q, done_nxt;
    logic             tmo_q, tmo_nxt;
    logic             is_wait, at_max, adv, forced;

    assign is_wait = WAIT_MASK[idx_q];
    assign at_max  = (wc_q == WMAX);
    assign adv     = !stall && (!is_wait || ready || at_max);
    assign forced  = adv && is_wait && !ready && at_max;

    // Lowest unskipped phase above the current one; phase 0 when none remain.
    always_comb begin
        succ = '0;
        for (int j = N_PHASES - 1; j >= 0; j--) begin
            if (j > int'(idx_q) && !skip_mask[j]) begin
                succ = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            wc_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            idx_q   <= idx_nxt;
            wc_q    <= wc_nxt;
            cnt_q   <= cnt_nxt;
            first_q <= first_nxt;
            done_q  <= done_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    always_comb begin
        idx_nxt   = idx_q;
        wc_nxt    = wc_q;
        cnt_nxt   = cnt_q;
        first_nxt = 1'b0;
        done_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        if (adv) begin
            idx_nxt   = succ;
            wc_nxt    = '0;
            first_nxt = 1'b1;
            tmo_nxt   = forced;
            done_nxt  = (succ == '0);
            if (succ == '0) begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end else if (!stall && is_wait) begin
            wc_nxt = wc_q + 1'b1;
        end
    end

    always_comb begin
        phase        = '0;
        phase[idx_q] = 1'b1;
        phase_idx    = idx_q;
        phase_first  = first_q;
        cycle_done   = done_q;
        timeout      = tmo_q;
        cycle_count  = cnt_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed per-cycle vectors,
// expected state queued by the driver and checked by a monitor.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] skip_mask = 4'b0000;
    logic       ready = 1'b1;

    logic [3:0]  phase, phase2;
    logic [1:0]  phase_idx, phase_idx2;
    logic        phase_first, phase_first2;
    logic        cycle_done, cycle_done2;
    logic        timeout, timeout2;
    logic [15:0] cycle_count;
    logic [1:0]  cycle_count2;

    typedef struct {
        bit chk;
        int idx;
        int first;
        int done;
        int tmo;
        int cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .skip_mask(skip_mask), .ready(ready),
        .phase(phase), .phase_idx(phase_idx),
        .phase_first(phase_first), .cycle_done(cycle_done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    phase_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .skip_mask(skip_mask), .ready(ready),
        .phase(phase2), .phase_idx(phase_idx2),
        .phase_first(phase_first2), .cycle_done(cycle_done2),
        .timeout(timeout2), .cycle_count(cycle_count2)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs applied for this cycle; expectation is the state seen in it.
    task automatic row(input bit r, input bit s, input logic [3:0] sk,
                       input bit rd, input bit c, input int i, input int f,
                       input int d, input int t, input int n);
        exp_t e;
        @(posedge clk);
        #1;
        e = '{c, i, f, d, t, n};
        q.push_back(e);
        rst_n = r;
        stall = s;
        skip_mask = sk;
        ready = rd;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) begin
                check("phase", int'(phase), 1 << e.idx);
                check("phase_idx", int'(phase_idx), e.idx);
                check("phase_first", int'(phase_first), e.first);
                check("cycle_done", int'(cycle_done), e.done);
                check("timeout", int'(timeout), e.tmo);
                check("cycle_count", int'(cycle_count), e.cnt);
                check("cycle_count_w2", int'(cycle_count2), e.cnt % 4);
            end
        end
    end

    initial begin
        // reset, then free run
        row(0,0,4'h0,1, 0, 0,0,0,0,0);
        row(0,0,4'h0,1, 1, 0,1,0,0,0);
        row(1,0,4'h0,1, 1, 0,1,0,0,0);
        row(1,0,4'h0,1, 1, 1,1,0,0,0);
        row(1,0,4'h0,1, 1, 2,1,0,0,0);
        row(1,0,4'h0,1, 1, 3,1,0,0,0);
        row(1,0,4'h0,0, 1, 0,1,1,0,1);
        // ready rises 3 cycles into rdmem
        row(1,0,4'h0,0, 1, 1,1,0,0,1);
        row(1,0,4'h0,0, 1, 2,1,0,0,1);
        row(1,0,4'h0,0, 1, 3,1,0,0,1);
        row(1,0,4'h0,0, 1, 3,0,0,0,1);
        row(1,0,4'h0,0, 1, 3,0,0,0,1);
        row(1,0,4'h0,1, 1, 3,0,0,0,1);
        row(1,0,4'h0,0, 1, 0,1,1,0,2);
        // ready held low: timeout
        row(1,0,4'h0,0, 1, 1,1,0,0,2);
        row(1,0,4'h0,0, 1, 2,1,0,0,2);
        row(1,0,4'h0,0, 1, 3,1,0,0,2);
        for (int k = 0; k < 7; k++) row(1,0,4'h0,0, 1, 3,0,0,0,2);
        // skip exec, then skip everything
        row(1,0,4'h4,1, 1, 0,1,1,1,3);
        row(1,0,4'h4,1, 1, 1,1,0,0,3);
        row(1,0,4'h4,1, 1, 3,1,0,0,3);
        row(1,0,4'hf,1, 1, 0,1,1,0,4);
        row(1,0,4'hf,1, 1, 0,1,1,0,5);
        row(1,0,4'h0,1, 1, 0,1,1,0,6);
        // stall in decode, then one stall cycle at wait_cnt 6
        row(1,1,4'h0,0, 1, 1,1,0,0,6);
        for (int k = 0; k < 4; k++) row(1,1,4'h0,0, 1, 1,0,0,0,6);
        row(1,0,4'h0,0, 1, 1,0,0,0,6);
        row(1,0,4'h0,0, 1, 2,1,0,0,6);
        row(1,0,4'h0,0, 1, 3,1,0,0,6);
        for (int k = 0; k < 5; k++) row(1,0,4'h0,0, 1, 3,0,0,0,6);
        row(1,1,4'h0,0, 1, 3,0,0,0,6);
        row(1,0,4'h0,0, 1, 3,0,0,0,6);
        row(1,0,4'h0,0, 1, 3,0,0,0,6);
        row(1,0,4'h0,0, 1, 0,1,1,1,7);
        // reset mid-wait at wait_cnt 4
        row(1,0,4'h0,0, 1, 1,1,0,0,7);
        row(1,0,4'h0,0, 1, 2,1,0,0,7);
        row(1,0,4'h0,0, 1, 3,1,0,0,7);
        for (int k = 0; k < 3; k++) row(1,0,4'h0,0, 1, 3,0,0,0,7);
        row(0,0,4'h0,0, 1, 3,0,0,0,7);
        row(1,0,4'h0,1, 1, 0,1,0,0,0);
        row(1,0,4'h0,1, 1, 1,1,0,0,0);
        row(1,0,4'h0,1, 1, 2,1,0,0,0);
        row(1,0,4'h0,1, 1, 3,1,0,0,0);
        // count wrap on the 2-bit instance
        row(1,0,4'hf,1, 1, 0,1,1,0,1);
        row(1,0,4'hf,1, 1, 0,1,1,0,2);
        row(1,0,4'hf,1, 1, 0,1,1,0,3);
        row(1,0,4'hf,1, 1, 0,1,1,0,4);
        row(1,0,4'h0,1, 1, 0,1,1,0,5);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
